// File: rtl/egg_timer_pkg.sv
// Shared types and helpers for the egg timer bank: channel FSM states and
// the channel-index width derivation used for the load_chan port.
package egg_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  // Width of a channel index; at least one bit even for a single channel.
  function automatic int chan_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/egg_timer_chan.sv
// One timer channel: counts a loaded period down to expiry, either once or
// with automatic reload, and can be cancelled at any time while running.
module egg_timer_chan
  import egg_timer_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             periodic_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             expire_o
);

  chan_state_t      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             periodic_q, periodic_d;
  logic             expire_q, expire_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_i && (value_i != '0)) begin
          state_d    = RUN;
          count_d    = value_i;
          period_d   = value_i;
          periodic_d = periodic_i;
        end
      end
      RUN: begin
        // Expiry fires on the edge where count would reach zero, so the
        // count itself never has to represent zero while running.
        if (cancel_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == WIDTH'(1)) begin
          expire_d = 1'b1;
          if (periodic_q) begin
            count_d = period_q;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
    end
  end

  assign busy_o   = (state_q == RUN);
  assign expire_o = expire_q;

endmodule

// File: rtl/egg_timer_bank.sv
// Bank of independent countdown timers sharing a single load port, with
// per-channel cancel, expiry pulses and a post-reset selection pulse.
module egg_timer_bank
  import egg_timer_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 7,
  localparam int CW       = chan_idx_width(CHANNELS)
) (
  input  logic                sysclk,
  input  logic                reset_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CW-1:0]       load_chan,
  input  logic [WIDTH-1:0]    load_value,
  input  logic                load_periodic,
  input  logic [CHANNELS-1:0] cancel,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] expire,
  output logic                load_err,
  output logic                selection
);

  logic [CHANNELS-1:0] hit;
  logic                chan_in_range;
  logic                chan_busy;
  logic                accept;
  logic                value_zero;
  logic                sel_q, sel_d;
  logic                rel_q, rel_d;
  logic                load_err_q, load_err_d;

  // An index beyond the last channel matches nothing, so such loads are
  // accepted (never busy) but reach no channel and raise no error.
  assign chan_in_range = |hit;
  assign chan_busy     = |(hit & busy);
  assign load_ready    = ~chan_busy & ~sel_q;
  assign accept        = load_valid & load_ready;
  assign value_zero    = (load_value == '0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign hit[c] = (load_chan == CW'(c));

    egg_timer_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_i      (sysclk),
      .rst_ni     (reset_n),
      .load_i     (accept & hit[c]),
      .value_i    (load_value),
      .periodic_i (load_periodic),
      .cancel_i   (cancel[c]),
      .busy_o     (busy[c]),
      .expire_o   (expire[c])
    );
  end

  always_comb begin
    rel_d      = 1'b1;
    sel_d      = ~rel_q;
    load_err_d = accept & chan_in_range & value_zero;
  end

  // selection holds through reset and one cycle past the first released edge.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      sel_q      <= 1'b1;
      rel_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      rel_q      <= rel_d;
      load_err_q <= load_err_d;
    end
  end

  assign selection = sel_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_egg_timer_bank.sv
// Randomized scoreboard bench for egg_timer_bank: a deadline-based model
// predicts every cycle's outputs, and a negedge monitor compares them.
module tb_egg_timer_bank;

  localparam int CH = 4;
  localparam int W  = 7;
  localparam int CW = 2;

  logic          sysclk = 1'b0;
  logic          reset_n;
  logic          load_valid;
  logic          load_ready;
  logic [CW-1:0] load_chan;
  logic [W-1:0]  load_value;
  logic          load_periodic;
  logic [CH-1:0] cancel;
  logic [CH-1:0] busy;
  logic [CH-1:0] expire;
  logic          load_err;
  logic          selection;

  always #5 sysclk = ~sysclk;

  egg_timer_bank #(
    .CHANNELS(CH),
    .WIDTH(W)
  ) dut (
    .sysclk        (sysclk),
    .reset_n       (reset_n),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_chan     (load_chan),
    .load_value    (load_value),
    .load_periodic (load_periodic),
    .cancel        (cancel),
    .busy          (busy),
    .expire        (expire),
    .load_err      (load_err),
    .selection     (selection)
  );

  typedef struct packed {
    logic [CH-1:0] busy;
    logic [CH-1:0] expire;
    logic          err;
    logic          sel;
    logic          ready;
    logic [31:0]   cyc;
  } exp_t;

  exp_t expq[$];
  bit   started = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: absolute edge numbers of the next expiry per channel.
  bit          active[CH];
  longint      deadline[CH];
  int unsigned period[CH];
  bit          periodic[CH];
  longint      edge_n = 0;
  logic [CH-1:0] m_exp = '0;
  bit          m_err = 1'b0;
  int          since = 0;

  function automatic bit m_sel();
    return since <= 1;
  endfunction

  function automatic logic [CH-1:0] m_busy();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = active[c];
    return r;
  endfunction

  function automatic bit m_ready(input logic [CW-1:0] ch);
    bit b;
    b = (int'(ch) < CH) ? active[int'(ch)] : 1'b0;
    return !m_sel() && !b;
  endfunction

  task automatic model_edge(input logic rst, input logic lv, input logic [CW-1:0] ch,
                            input logic [W-1:0] val, input logic per,
                            input logic [CH-1:0] can);
    bit acc;
    acc = lv && m_ready(ch);
    edge_n++;
    if (!rst) begin
      for (int c = 0; c < CH; c++) active[c] = 1'b0;
      m_exp = '0;
      m_err = 1'b0;
      since = 0;
      return;
    end
    if (since < 2) since++;
    m_exp = '0;
    for (int c = 0; c < CH; c++) begin
      if (active[c]) begin
        if (can[c]) begin
          active[c] = 1'b0;
        end else if (edge_n == deadline[c]) begin
          m_exp[c] = 1'b1;
          if (periodic[c]) deadline[c] = deadline[c] + period[c];
          else active[c] = 1'b0;
        end
      end else if (acc && int'(ch) == c && val != 0) begin
        active[c]   = 1'b1;
        deadline[c] = edge_n + longint'(val);
        period[c]   = int'(val);
        periodic[c] = per;
      end
    end
    m_err = acc && (int'(ch) < CH) && (val == 0);
  endtask

  task automatic step(input logic rst, input logic lv, input logic [CW-1:0] ch,
                      input logic [W-1:0] val, input logic per,
                      input logic [CH-1:0] can);
    exp_t e;
    reset_n       = rst;
    load_valid    = lv;
    load_chan     = ch;
    load_value    = val;
    load_periodic = per;
    cancel        = can;
    e.busy   = m_busy();
    e.expire = m_exp;
    e.err    = m_err;
    e.sel    = m_sel();
    e.ready  = m_ready(ch);
    e.cyc    = 32'(edge_n);
    expq.push_back(e);
    @(posedge sysclk);
    model_edge(rst, lv, ch, val, per, can);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want,
                     input logic [31:0] cyc);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s edge=%0d got=%h expected=%h", nm, cyc, got, want);
  endtask

  always @(negedge sysclk) begin
    if (started) begin
      if (expq.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty time=%0t got=0 expected>0", $time);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("busy",       32'(busy),       32'(e.busy),   e.cyc);
        chk("expire",     32'(expire),     32'(e.expire), e.cyc);
        chk("load_err",   32'(load_err),   32'(e.err),    e.cyc);
        chk("selection",  32'(selection),  32'(e.sel),    e.cyc);
        chk("load_ready", 32'(load_ready), 32'(e.ready),  e.cyc);
      end
    end
  end

  initial begin
    logic [W-1:0]  v;
    logic [CH-1:0] cm;
    reset_n = 1'b0; load_valid = 1'b0; load_chan = '0; load_value = '0;
    load_periodic = 1'b0; cancel = '0;
    for (int c = 0; c < CH; c++) begin
      active[c] = 1'b0; deadline[c] = 0; period[c] = 0; periodic[c] = 1'b0;
    end
    @(posedge sysclk);
    model_edge(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    started = 1'b1;

    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 2'd1, 7'd5, 1'b0, '0);
    idle(3);
    // One-shot, periodic with cancel on the third expiry edge.
    step(1'b1, 1'b1, 2'd1, 7'd5, 1'b0, '0);
    idle(8);
    step(1'b1, 1'b1, 2'd0, 7'd3, 1'b1, '0);
    idle(8);
    step(1'b1, 1'b0, '0, '0, 1'b0, 4'b0001);
    idle(3);
    // Zero-value load, then a retry on a busy channel.
    step(1'b1, 1'b1, 2'd2, 7'd0, 1'b0, '0);
    idle(1);
    step(1'b1, 1'b1, 2'd3, 7'd10, 1'b0, '0);
    step(1'b1, 1'b1, 2'd3, 7'd4, 1'b0, '0);
    idle(12);
    // Cancel on idle channel alongside a load to it.
    step(1'b1, 1'b1, 2'd2, 7'd1, 1'b1, 4'b0100);
    idle(3);
    step(1'b1, 1'b0, '0, '0, 1'b0, 4'b0100);
    idle(2);
    // Staggered loads chosen so all four channels expire on one edge.
    step(1'b1, 1'b1, 2'd0, 7'd127, 1'b0, '0);
    step(1'b1, 1'b1, 2'd1, 7'd126, 1'b0, '0);
    step(1'b1, 1'b1, 2'd2, 7'd125, 1'b0, '0);
    step(1'b1, 1'b1, 2'd3, 7'd124, 1'b0, '0);
    idle(130);
    for (int c = 0; c < CH; c++) step(1'b1, 1'b1, CW'(c), 7'd127, 1'b0, '0);
    idle(60);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle(140);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) v = 7'd127;
      else if ($urandom_range(0, 3) == 0) v = W'($urandom);
      else v = W'($urandom_range(0, 6));
      for (int c = 0; c < CH; c++) cm[c] = ($urandom_range(0, 11) == 0);
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 1) == 1),
           CW'($urandom_range(0, CH - 1)), v, ($urandom_range(0, 1) == 1), cm);
    end

    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/egg_timer_bank.md
EGG_TIMER_BANK -- requirements
Module: egg_timer_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 7, counter width per channel in bits (2..32).
REQ-003 The block SHALL have port sysclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port load_valid  input  1  load request.
REQ-006 The block SHALL have port load_ready  output  1  load acceptance.
REQ-007 The block SHALL have port load_chan  input  CW=max(1,clog2(CHANNELS))  target channel.
REQ-008 The block SHALL have port load_value  input  WIDTH  period V in cycles.
REQ-009 The block SHALL have port load_periodic  input  1  1 = auto-reload, 0 = one-shot.
REQ-010 The block SHALL have port cancel  input  CHANNELS  per-channel stop mask.
REQ-011 The block SHALL have port busy  output  CHANNELS  channel running.
REQ-012 The block SHALL have port expire  output  CHANNELS  one-cycle expiry pulses.
REQ-013 The block SHALL have port load_err  output  1  one-cycle pulse on an accepted zero-value load.
REQ-014 The block SHALL have port selection  output  1  one-cycle pulse in the first cycle after reset release.

Function
REQ-015 Each channel SHALL have two states, IDLE and RUN, plus a WIDTH-bit count and a WIDTH-bit stored period.
REQ-016 load_ready SHALL be combinationally ~busy[load_chan] & ~selection; a load is accepted at an edge where load_valid & load_ready.
REQ-017 On an accepted load with V>0, the channel SHALL enter RUN with count=V and period=V; busy rises at that edge.
REQ-018 An accepted load with V=0 SHALL leave the channel IDLE and assert load_err for the following cycle.
REQ-019 In RUN, count SHALL decrement by 1 per cycle; expire[c] SHALL be high exactly in the cycle following the V-th edge after the accepting edge.
REQ-020 One-shot: at expiry the channel SHALL return to IDLE and busy[c] SHALL fall in the same cycle that expire[c] is high.
REQ-021 Periodic: at expiry count SHALL reload to period, busy stays high, and expire pulses every V cycles (V=1: every cycle).
REQ-022 cancel[c] in RUN SHALL force IDLE at the next edge; if cancel and expiry coincide, cancel wins and no expire pulse is issued.
REQ-023 cancel[c] on an IDLE channel SHALL have no effect; a same-cycle load to that channel still proceeds.
REQ-024 Loads to a busy channel SHALL be held off (load_ready=0) until the channel is idle; there SHALL be no reload-while-running.
REQ-025 V = 2^WIDTH-1 SHALL work without overflow; count never wraps below zero.
REQ-026 load_chan >= CHANNELS SHALL be accepted and discarded, with no state change and no load_err.
REQ-027 Channels SHALL be fully independent; simultaneous expiries on several channels SHALL all pulse in the same cycle.

Reset
REQ-028 While reset_n=0 at an edge, all channels SHALL go IDLE with count=0 and period=0, and busy, expire, and load_err SHALL be 0.
REQ-029 selection SHALL be 1 in reset and SHALL stay 1 for exactly one cycle after the first edge with reset_n=1, then drop to 0.
REQ-030 Reset asserted mid-count SHALL abort all channels with no expire pulse.

Structure
REQ-031 Package egg_timer_pkg SHALL hold the chan_state_t typedef (IDLE, RUN) and the channel-index-width helper function.
REQ-032 The per-channel counter and FSM SHALL be a sub-module egg_timer_chan, instantiated CHANNELS times by a generate loop.

Verification
REQ-033 Reset release: selection is high for one cycle and load_ready is 0 in that cycle; busy=0 and expire=0 throughout.
REQ-034 One-shot load of chan 1 with V=5: busy[1] is high for 5 cycles and expire[1] pulses once, 5 cycles after accept; no further pulses.
REQ-035 Periodic load of chan 0 with V=3: expire[0] at +3, +6, +9; cancel[0] asserted in the cycle of the +9 expiry suppresses that pulse, and busy[0] falls.
REQ-036 Load with V=0: load_err pulses once, busy stays 0; a retry load on the busy channel shows load_ready=0 and is not accepted.
REQ-037 CHANNELS=4, WIDTH=7, all channels loaded with V=127: all four expire bits pulse in the same cycle; reset_n=0 applied mid-run yields no pulses.
